// File: rtl/hamdist_pop_core_if.sv
// Request/response bundle between the HamDistPop register slave (master) and its compute core (slave).
interface hamdist_pop_core_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_op_a;
  logic [DATA_WIDTH-1:0] in_op_b;
  logic                  in_mode;
  logic                  in_acc;
  logic                  acc_clr;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_result;
  logic                  busy;

  modport master (
    output in_valid, in_op_a, in_op_b, in_mode, in_acc, acc_clr, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op_a, in_op_b, in_mode, in_acc, acc_clr, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/hamdist_pop_core.sv
// Chunked popcount / Hamming-distance engine with optional saturating accumulator.
// Optional macro HDP_PERF_CNT_EN adds a 32-bit handshake counter port perf_ops.
module hamdist_pop_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  hamdist_pop_core_if.slave    bus
`ifdef HDP_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ops
`endif
);

  localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] work;
  logic [IDX_W-1:0]      idx;
  logic [CNT_W-1:0]      count, chunk_pop, count_next;
  logic                  acc_sel;
  logic [ACC_WIDTH-1:0]  acc, result, acc_sum_sat;
  logic [ACC_WIDTH:0]    acc_sum;
  logic                  accept, handshake, last_chunk;

  // One extra sum bit exposes overflow so the accumulator saturates instead of wrapping.
  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      chunk_pop = chunk_pop + CNT_W'(work[i]);
    end
    count_next  = count + chunk_pop;
    acc_sum     = {1'b0, acc} + (ACC_WIDTH+1)'(count_next);
    acc_sum_sat = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
    last_chunk  = (idx == IDX_W'(N - 1));
  end

  assign accept    = (state == IDLE) && bus.in_valid;
  assign handshake = (state == DONE) && bus.out_ready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
        if (accept) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (handshake) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A clear and an accept on the same edge: the clear lands first, the accepted op then sums from 0.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      work    <= '0;
      idx     <= '0;
      count   <= '0;
      acc_sel <= 1'b0;
      acc     <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.acc_clr) acc <= '0;
          if (accept) begin
            work    <= bus.in_mode ? (bus.in_op_a ^ bus.in_op_b) : bus.in_op_a;
            acc_sel <= bus.in_acc;
            count   <= '0;
            idx     <= '0;
          end
        end
        RUN: begin
          work  <= work >> CHUNK_WIDTH;
          count <= count_next;
          idx   <= idx + 1'b1;
          if (last_chunk) begin
            if (acc_sel) begin
              result <= acc_sum_sat;
              acc    <= acc_sum_sat;
            end else begin
              result <= ACC_WIDTH'(count_next);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_result = result;

`ifdef HDP_PERF_CNT_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)       perf_ops <= '0;
    else if (handshake) perf_ops <= perf_ops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hamdist_pop_core.sv
// Scoreboard bench for hamdist_pop_core: a 32-bit accumulator instance and a 6-bit one for saturation.
module tb_hamdist_pop_core;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] sb[$];
  logic [31:0] sb6[$];
  logic [31:0] exp_m;
  logic [31:0] exp_m6;

  always #5 ACLK = ~ACLK;

  hamdist_pop_core_if #(.DATA_WIDTH(32), .ACC_WIDTH(32)) bus();
  hamdist_pop_core_if #(.DATA_WIDTH(32), .ACC_WIDTH(6))  bus6();

`ifdef HDP_PERF_CNT_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_ops6;
`endif

  hamdist_pop_core #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(32)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
`ifdef HDP_PERF_CNT_EN
    ,
    .perf_ops(perf_ops)
`endif
  );

  hamdist_pop_core #(.DATA_WIDTH(32), .CHUNK_WIDTH(8), .ACC_WIDTH(6)) dut6 (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus6)
`ifdef HDP_PERF_CNT_EN
    ,
    .perf_ops(perf_ops6)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one request for a single accept edge and records its expected result.
  task automatic applyStimulus(input int which, input logic [31:0] a, input logic [31:0] b,
                               input logic mode, input logic acc, input logic clr,
                               input logic [31:0] expected);
    int guard = 0;
    while (((which == 0) ? !bus.in_ready : !bus6.in_ready) && guard < 200) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end
    if (which == 0) begin
      bus.in_op_a = a; bus.in_op_b = b; bus.in_mode = mode; bus.in_acc = acc;
      bus.acc_clr = clr; bus.in_valid = 1'b1;
      sb.push_back(expected);
    end else begin
      bus6.in_op_a = a; bus6.in_op_b = b; bus6.in_mode = mode; bus6.in_acc = acc;
      bus6.acc_clr = clr; bus6.in_valid = 1'b1;
      sb6.push_back(expected);
    end
    @(posedge ACLK); #1;
    if (which == 0) begin
      bus.in_valid = 1'b0; bus.acc_clr = 1'b0;
    end else begin
      bus6.in_valid = 1'b0; bus6.acc_clr = 1'b0;
    end
  endtask

  task automatic waitIdle(input int which);
    int guard = 0;
    while (((which == 0) ? bus.busy : bus6.busy) && guard < 200) begin
      @(posedge ACLK); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // Monitor: every completed output handshake is matched against the oldest queued expectation.
  always @(negedge ACLK) begin
    if (ARESETN && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result actual=0x%0h required=none", bus.out_result);
      end else begin
        exp_m = sb.pop_front();
        checkOutput("result", bus.out_result, exp_m);
      end
    end
    if (ARESETN && bus6.out_valid && bus6.out_ready) begin
      if (sb6.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result6 actual=0x%0h required=none", bus6.out_result);
      end else begin
        exp_m6 = sb6.pop_front();
        checkOutput("result6", 32'(bus6.out_result), exp_m6);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    int busy_cycles;
    int guard;

    bus.in_valid = 0; bus.in_op_a = 0; bus.in_op_b = 0; bus.in_mode = 0;
    bus.in_acc = 0; bus.acc_clr = 0; bus.out_ready = 1;
    bus6.in_valid = 0; bus6.in_op_a = 0; bus6.in_op_b = 0; bus6.in_mode = 0;
    bus6.in_acc = 0; bus6.acc_clr = 0; bus6.out_ready = 1;

    repeat (3) @(posedge ACLK);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_out_result", bus.out_result, 32'd0);
`ifdef HDP_PERF_CNT_EN
    checkOutput("rst_perf_ops", perf_ops, 32'd0);
`endif
    ARESETN = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_in_ready6", 32'(bus6.in_ready), 32'd1);
    @(posedge ACLK); #1;

    // Popcount of all ones, with latency and busy-window measurement.
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 32'd32);
    lat = -1;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) busy_cycles++;
      if (bus.out_valid && lat < 0) lat = i;
      @(posedge ACLK); #1;
    end
    checkOutput("latency", 32'(lat), 32'd4);
    checkOutput("busy_cycles", 32'(busy_cycles), 32'd5);

    applyStimulus(0, 32'h0000_000F, 32'h0000_00F0, 1'b1, 1'b0, 1'b0, 32'd8);
    applyStimulus(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'd2);

    // Accumulation, clear in IDLE, clear ignored in RUN, clear coinciding with accept.
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd32);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd64);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd96);
    waitIdle(0);
    bus.acc_clr = 1'b1;
    @(posedge ACLK); #1;
    bus.acc_clr = 1'b0;
    applyStimulus(0, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0, 32'd1);
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd33);
    bus.acc_clr = 1'b1;
    @(posedge ACLK); #1;
    bus.acc_clr = 1'b0;
    applyStimulus(0, 32'h0000_000F, 32'h0, 1'b0, 1'b1, 1'b0, 32'd37);
    applyStimulus(0, 32'h0000_0007, 32'h0, 1'b0, 1'b1, 1'b1, 32'd3);

    // Backpressure: result held, a waiting request is refused until the handshake.
    waitIdle(0);
    bus.out_ready = 1'b0;
    applyStimulus(0, 32'h00FF_00FF, 32'h0, 1'b0, 1'b0, 1'b0, 32'd16);
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(posedge ACLK); #1;
      guard++;
    end
    checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_op_a = 32'h0000_0001; bus.in_op_b = 32'h0; bus.in_mode = 1'b0;
    bus.in_acc = 1'b0; bus.in_valid = 1'b1;
    sb.push_back(32'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_hold", bus.out_result, 32'd16);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge ACLK); #1;
    end
    checkOutput("bp_still_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge ACLK); #1;
    checkOutput("bp_idle_after_hs", 32'(bus.busy), 32'd0);
    checkOutput("bp_ready_after_hs", 32'(bus.in_ready), 32'd1);
    @(posedge ACLK); #1;
    checkOutput("bp_accepted", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    waitIdle(0);

    // Saturation on the narrow accumulator: 32, then 64 clipped to 63.
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd32);
    applyStimulus(1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd63);
    applyStimulus(1, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0, 32'd63);
    waitIdle(1);

    // Reset two cycles into RUN discards the op and the accumulated value.
    applyStimulus(0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 32'd35);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b0;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef HDP_PERF_CNT_EN
    checkOutput("perf_after_rst", perf_ops, 32'd0);
`endif
    applyStimulus(0, 32'h0000_0003, 32'h0, 1'b0, 1'b1, 1'b0, 32'd2);
    applyStimulus(0, 32'h0000_00F0, 32'h0, 1'b0, 1'b1, 1'b0, 32'd6);
    applyStimulus(0, 32'h0000_00FF, 32'h0000_000F, 1'b1, 1'b1, 1'b0, 32'd10);
    waitIdle(0);
`ifdef HDP_PERF_CNT_EN
    checkOutput("perf_three_ops", perf_ops, 32'd3);
`endif

    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("sb6_drained", 32'(sb6.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
